// File: rtl/dz_pkg.sv
// Shared types for the dot-matrix countdown: FSM states, colour codes and
// the digit-to-colour mapping used by the renderer.
package dz_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [1:0] COL_OFF = 2'b00;
   localparam logic [1:0] COL_RED = 2'b01;
   localparam logic [1:0] COL_GRN = 2'b10;
   localparam logic [1:0] COL_YEL = 2'b11;

   function automatic logic [1:0] color_of(input logic [2:0] n);
      logic [1:0] c;
      c = COL_OFF;
      if (n >= 3'd4)      c = COL_RED;
      else if (n >= 3'd2) c = COL_GRN;
      else                c = COL_YEL;
      return c;
   endfunction

endpackage

// File: rtl/dz_row_scan.sv
// Free-running row scanner: one row every SCAN_DIV cycles, wrapping 7 -> 0,
// with the one-hot row select shared by renderer and matrix drivers.
module dz_row_scan #(
   parameter int SCAN_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] row_idx,
   output logic [7:0] row_sel
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

   logic [SW-1:0] scan_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         row_idx  <= 3'd0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt <= '0;
         row_idx  <= row_idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign row_sel = 8'd1 << row_idx;

endmodule

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer for the dot-matrix digit: START_NUM down to 0, then a
// blink phase, plus the row scan shared with the renderer.
module dz_countdown_ctrl
   import dz_pkg::*;
#(
   parameter int TICK_DIV    = 1000,
   parameter int SCAN_DIV    = 1,
   parameter int START_NUM   = 5,
   parameter int BLINK_STEPS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [2:0] num,
   output logic [1:0] color,
   output logic       blank,
   output logic [2:0] row_idx,
   output logic [7:0] row_sel,
   output logic       busy,
   output logic       done
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = $clog2(2 * BLINK_STEPS);
   localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(2 * BLINK_STEPS - 1);
   localparam logic [2:0]    NUM_INIT  = 3'(START_NUM);

   state_t        state, state_nxt;
   logic [TW-1:0] tick_cnt, tick_nxt;
   logic [BW-1:0] blink_cnt, blink_nxt;
   logic [2:0]    num_nxt;
   logic          blank_nxt, done_nxt;
   logic          tick_exp;

   assign tick_exp = (tick_cnt == TICK_MAX);

   always_comb begin
      state_nxt = state;
      num_nxt   = num;
      tick_nxt  = tick_cnt;
      blank_nxt = blank;
      blink_nxt = blink_cnt;
      done_nxt  = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         num_nxt   = NUM_INIT;
         tick_nxt  = '0;
         blank_nxt = 1'b0;
         blink_nxt = '0;
      end else if (start) begin
         state_nxt = RUN;
         num_nxt   = NUM_INIT;
         tick_nxt  = '0;
         blank_nxt = 1'b0;
         blink_nxt = '0;
      end else begin
         case (state)
            RUN: begin
               // a pause edge freezes the tick counter on that same edge
               if (pause) begin
                  state_nxt = PAUSE;
               end else if (tick_exp) begin
                  tick_nxt = '0;
                  num_nxt  = num - 3'd1;
                  if (num == 3'd1) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                     blink_nxt = '0;
                  end
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
            PAUSE: begin
               if (pause) state_nxt = RUN;
            end
            DONE: begin
               if (tick_exp) begin
                  tick_nxt  = '0;
                  blank_nxt = ~blank;
                  if (blink_cnt == BLINK_MAX) begin
                     state_nxt = IDLE;
                     blank_nxt = 1'b0;
                     num_nxt   = NUM_INIT;
                     blink_nxt = '0;
                  end else begin
                     blink_nxt = blink_cnt + 1'b1;
                  end
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         num       <= NUM_INIT;
         tick_cnt  <= '0;
         blink_cnt <= '0;
         blank     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         num       <= num_nxt;
         tick_cnt  <= tick_nxt;
         blink_cnt <= blink_nxt;
         blank     <= blank_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
      end
   end

   assign color = color_of(num);

   dz_row_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_row_scan (
      .clk     (clk),
      .rst     (rst),
      .row_idx (row_idx),
      .row_sel (row_sel)
   );

endmodule

// File: tb/tb_dz_countdown_ctrl.sv
// Bench for dz_countdown_ctrl: directed scenarios plus randomized control
// pulses checked against an elapsed-time model of the countdown.
module tb_dz_countdown_ctrl;

   localparam int TD = 4;
   localparam int SD = 2;
   localparam int SN = 5;
   localparam int BS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [2:0] num, row_idx;
   logic [1:0] color;
   logic       blank, busy, done;
   logic [7:0] row_sel;

   int n_checks = 0;
   int n_fail   = 0;

   // model: counting edges since start, pause flag, cycles since reset
   bit m_active, m_paused, m_done;
   int m_el, m_cyc;

   dz_countdown_ctrl #(
      .TICK_DIV (TD), .SCAN_DIV (SD), .START_NUM (SN), .BLINK_STEPS (BS)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .pause (pause), .clear (clear),
      .num (num), .color (color), .blank (blank), .row_idx (row_idx),
      .row_sel (row_sel), .busy (busy), .done (done)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input bit s, input bit p, input bit c);
      int n;
      m_done = 1'b0;
      m_cyc++;
      if (c) begin
         m_active = 0; m_paused = 0; m_el = 0;
      end else if (s) begin
         m_active = 1; m_paused = 0; m_el = 0;
      end else if (m_active) begin
         n = m_el / TD;
         if (p && n < SN) m_paused = !m_paused;
         else if (!m_paused) begin
            m_el++;
            if (m_el == SN * TD) m_done = 1'b1;
            if (m_el == (SN + 2 * BS) * TD) begin
               m_active = 0; m_el = 0;
            end
         end
      end
   endtask

   function automatic logic [2:0] exp_num();
      int n;
      n = m_el / TD;
      if (!m_active) return 3'(SN);
      return (n < SN) ? 3'(SN - n) : 3'd0;
   endfunction

   function automatic logic exp_blank();
      int n;
      n = m_el / TD;
      return m_active && n >= SN && ((n - SN) % 2 == 1);
   endfunction

   function automatic logic [1:0] exp_color(input logic [2:0] v);
      if (v >= 4) return 2'b01;
      if (v >= 2) return 2'b10;
      return 2'b11;
   endfunction

   // drive one edge's worth of controls, then return at the following negedge
   task automatic tick(input bit s, input bit p, input bit c);
      start = s; pause = p; clear = c;
      @(posedge clk);
      model_edge(s, p, c);
      @(negedge clk);
      start = 0; pause = 0; clear = 0;
   endtask

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_done = 0; m_el = 0; m_cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_checks++; if (num !== 3'd5) begin n_fail++; $display("FAIL reset_num got %0d want 5", num); end
      n_checks++; if (color !== 2'b01) begin n_fail++; $display("FAIL reset_color got %b want 01", color); end
      n_checks++; if ({blank, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {blank, busy, done}); end
      n_checks++; if (row_sel !== 8'h01 || row_idx !== 3'd0) begin n_fail++; $display("FAIL reset_row got %h/%0d want 01/0", row_sel, row_idx); end
   endtask

   task automatic test_run_to_completion();
      tick(1, 0, 0);
      n_checks++; if (num !== 3'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL run_start got num %0d busy %b want 5 1", num, busy); end
      for (int k = 1; k <= 36; k++) begin
         tick(0, 0, 0);
         if (k == 3) begin n_checks++; if (num !== 3'd5) begin n_fail++; $display("FAIL run_e3 got %0d want 5", num); end end
         if (k == 4) begin n_checks++; if (num !== 3'd4 || color !== 2'b01) begin n_fail++; $display("FAIL run_e4 got %0d/%b want 4/01", num, color); end end
         if (k == 8) begin n_checks++; if (num !== 3'd3 || color !== 2'b10) begin n_fail++; $display("FAIL run_e8 got %0d/%b want 3/10", num, color); end end
         if (k == 12) begin n_checks++; if (num !== 3'd2 || color !== 2'b10) begin n_fail++; $display("FAIL run_e12 got %0d/%b want 2/10", num, color); end end
         if (k == 16) begin n_checks++; if (num !== 3'd1 || color !== 2'b11) begin n_fail++; $display("FAIL run_e16 got %0d/%b want 1/11", num, color); end end
         if (k == 19) begin n_checks++; if (done !== 1'b0 || num !== 3'd1) begin n_fail++; $display("FAIL run_e19 got done %b num %0d want 0 1", done, num); end end
         if (k == 20) begin n_checks++; if (num !== 3'd0 || done !== 1'b1 || color !== 2'b11 || blank !== 1'b0) begin n_fail++; $display("FAIL run_e20 got num %0d done %b col %b blank %b want 0 1 11 0", num, done, color, blank); end end
         if (k == 21) begin n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL run_done_pulse got %b want 0", done); end end
         if (k == 23) begin n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL run_e23 blank got %b want 0", blank); end end
         if (k == 24) begin n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL run_e24 blank got %b want 1", blank); end end
         if (k == 28) begin n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL run_e28 blank got %b want 0", blank); end end
         if (k == 32) begin n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL run_e32 blank got %b want 1", blank); end end
         if (k == 35) begin n_checks++; if (busy !== 1'b1 || num !== 3'd0) begin n_fail++; $display("FAIL run_e35 got busy %b num %0d want 1 0", busy, num); end end
         if (k == 36) begin n_checks++; if (num !== 3'd5 || blank !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL run_e36 got num %0d blank %b busy %b want 5 0 0", num, blank, busy); end end
      end
   endtask

   task automatic test_pause();
      tick(1, 0, 0);            // E0
      tick(0, 0, 0);            // E1
      tick(0, 1, 0);            // E2
      for (int k = 3; k <= 11; k++) tick(0, 0, 0);
      n_checks++; if (num !== 3'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL pause_hold got num %0d busy %b want 5 1", num, busy); end
      tick(0, 1, 0);            // E12
      tick(0, 0, 0);
      tick(0, 0, 0);            // E14
      n_checks++; if (num !== 3'd5) begin n_fail++; $display("FAIL pause_e14 got %0d want 5", num); end
      tick(0, 0, 0);            // E15
      n_checks++; if (num !== 3'd4) begin n_fail++; $display("FAIL pause_e15 got %0d want 4", num); end
      tick(0, 0, 1);
   endtask

   task automatic test_priority();
      tick(1, 0, 0);
      repeat (8) tick(0, 0, 0);
      n_checks++; if (num !== 3'd3) begin n_fail++; $display("FAIL prio_setup got %0d want 3", num); end
      tick(1, 0, 1);
      n_checks++; if (num !== 3'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_clear_start got num %0d busy %b want 5 0", num, busy); end
      tick(1, 0, 0);
      repeat (24) tick(0, 0, 0);
      n_checks++; if (num !== 3'd0 || blank !== 1'b1) begin n_fail++; $display("FAIL prio_done_setup got num %0d blank %b want 0 1", num, blank); end
      tick(1, 0, 0);
      n_checks++; if (num !== 3'd5 || blank !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL prio_restart got num %0d blank %b busy %b want 5 0 1", num, blank, busy); end
      repeat (4) tick(0, 0, 0);
      n_checks++; if (num !== 3'd4) begin n_fail++; $display("FAIL prio_restart_dec got %0d want 4", num); end
      tick(0, 1, 0);           // pause then clear from PAUSE
      tick(0, 0, 1);
      n_checks++; if (busy !== 1'b0 || num !== 3'd5) begin n_fail++; $display("FAIL prio_clear_pause got busy %b num %0d want 0 5", busy, num); end
   endtask

   task automatic test_scan();
      logic [7:0] hist [$];
      logic [7:0] want;
      for (int k = 0; k < 40; k++) begin
         tick(k % 7 == 0, k % 5 == 1, k % 11 == 3);
         want = 8'd1 << ((m_cyc / SD) % 8);
         n_checks++; if (row_sel !== want || row_idx !== 3'((m_cyc / SD) % 8)) begin n_fail++; $display("FAIL scan got %h want %h", row_sel, want); end
         hist.push_back(row_sel);
         if (hist.size() > 16) begin
            n_checks++; if (hist[0] !== row_sel) begin n_fail++; $display("FAIL scan_period got %h want %h", row_sel, hist[0]); end
            void'(hist.pop_front());
         end
      end
      tick(0, 0, 1);
   endtask

   task automatic test_reset_mid();
      tick(1, 0, 0);
      repeat (24) tick(0, 0, 0);
      n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup blank got %b want 1", blank); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (num !== 3'd5 || color !== 2'b01 || {blank, busy, done} !== 3'b000 || row_sel !== 8'h01 || row_idx !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_async got num %0d col %b flags %b row %h", num, color, {blank, busy, done}, row_sel);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      tick(1, 0, 0);
      repeat (4) tick(0, 0, 0);
      n_checks++; if (num !== 3'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_resume got num %0d busy %b want 4 1", num, busy); end
      tick(0, 0, 1);
   endtask

   task automatic test_random();
      bit s, p, c;
      logic [2:0] en;
      for (int k = 0; k < 2000; k++) begin
         s = ($urandom_range(0, 79) == 0);
         p = ($urandom_range(0, 14) == 0);
         c = ($urandom_range(0, 249) == 0);
         tick(s, p, c);
         en = exp_num();
         n_checks++; if (num !== en) begin n_fail++; $display("FAIL rand_num cyc %0d got %0d want %0d", k, num, en); end
         n_checks++; if (color !== exp_color(en)) begin n_fail++; $display("FAIL rand_color cyc %0d got %b want %b", k, color, exp_color(en)); end
         n_checks++; if (blank !== exp_blank()) begin n_fail++; $display("FAIL rand_blank cyc %0d got %b want %b", k, blank, exp_blank()); end
         n_checks++; if (busy !== m_active) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", k, busy, m_active); end
         n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done cyc %0d got %b want %b", k, done, m_done); end
         n_checks++; if (row_sel !== (8'd1 << ((m_cyc / SD) % 8))) begin n_fail++; $display("FAIL rand_row cyc %0d got %h", k, row_sel); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_to_completion();
      test_pause();
      test_priority();
      test_scan();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
